master_wr_data_fifo_drain: RTL and testbench
============================================

Name: master_wr_data_fifo_drain

Overview:
Read-side consumer of the 72-bit master write-data async FIFO. It accepts a burst command (AXI length), pops exactly len+1 words from the FIFO read port, and drives them on an AXI4 master W channel with correct WLAST. A 3-entry output buffer hides the FIFO's 1-cycle read latency and sustains one beat per cycle under WREADY backpressure. The block sits in the rd_clk domain, between the FIFO and the AXI4 master interconnect.

Parameters:
DATA_WIDTH, 64, W channel data width
STRB_WIDTH, 8, W channel strobe width (DATA_WIDTH/8)
FIFO_WIDTH, 72, FIFO word width; must equal DATA_WIDTH+STRB_WIDTH
LEN_WIDTH, 8, AXI burst length field width

Ports:
clk  in  1  single clock; the FIFO rd_clk domain
rstn  in  1  asynchronous, active-low reset
cmd_valid  in  1  burst command valid
cmd_ready  out  1  burst command ready
cmd_len  in  LEN_WIDTH  AXI LEN; burst has cmd_len+1 beats
fifo_rd_en  out  1  FIFO read enable
fifo_rd_data  in  FIFO_WIDTH  FIFO read data, valid the cycle after fifo_rd_en
fifo_rd_empty  in  1  FIFO empty flag
m_axi_wvalid  out  1  W valid
m_axi_wready  in  1  W ready
m_axi_wdata  out  DATA_WIDTH  W data = fifo word [FIFO_WIDTH-1:STRB_WIDTH]
m_axi_wstrb  out  STRB_WIDTH  W strobe = fifo word [STRB_WIDTH-1:0]
m_axi_wlast  out  1  last beat of burst
busy  out  1  high while in BURST
burst_done  out  1  one-cycle pulse after the last beat handshake

Behaviour:
- Clock is clk. Reset is rstn, asynchronous and active-low. While rstn is low all outputs are 0: cmd_ready, fifo_rd_en, wvalid, wlast, wdata, wstrb, busy and burst_done. Buffer occupancy is cleared, the in-flight flag is cleared, and state is IDLE.
- cmd_ready is registered. It rises the first cycle after reset release and is 1 in IDLE only.
- States:
  - IDLE: on cmd_valid&&cmd_ready, load fetch_rem = send_rem = cmd_len+1 (LEN_WIDTH+1 bits, max 256), then go to BURST. cmd_ready drops the next cycle.
  - BURST: when the beat with send_rem==1 is handshaken, go to IDLE. burst_done=1 for exactly that following cycle, and cmd_ready=1 again in the same cycle.
- Read issue (combinational): fifo_rd_en = BURST && fetch_rem!=0 && !fifo_rd_empty && (occ+inflight)<=2. Here occ is buffer occupancy (0..3) and inflight is fifo_rd_en registered. fetch_rem decrements on each fifo_rd_en. fifo_rd_en never depends combinationally on m_axi_wready.
- Capture: when inflight=1, fifo_rd_data is written into the buffer tail at the end of that cycle.
- The buffer never overflows; this is guaranteed by the issue rule.
- Output:
  - wvalid = (occ!=0); the head entry drives wdata/wstrb.
  - wlast = wvalid && send_rem==1.
  - Pop on wvalid&&wready; send_rem decrements on each pop.
  - Once wvalid is asserted, wvalid, wdata, wstrb and wlast stay stable until the handshake.
- Latency:
  - Command handshake at cycle 0 → first fifo_rd_en at cycle 1 (if not empty) → first wvalid at cycle 3.
  - Steady state is 1 beat/cycle with wready=1 and FIFO non-empty.
  - There is one idle cycle between consecutive bursts.
- Simultaneous capture and pop in one cycle: occ is unchanged and order is preserved.
- If the FIFO is empty mid-burst, fifo_rd_en stays low and wvalid deasserts only after the buffer drains. No underflow reads are issued.
- cmd_len=0 gives a single beat with wlast=1.
- Reset mid-burst: the partial burst is dropped and buffer contents are discarded. The FIFO read side is reset by the same system reset.

Decomposition:
- Shared package master_wr_pkg holds:
  - the state enum (IDLE, BURST)
  - DATA/STRB/FIFO/LEN width constants
  - the data/strobe field offsets inside the FIFO word
  - the buffer depth constant (3)
- One sub-module, wdata_out_buf. It is a 3-entry FIFO_WIDTH buffer with push/pop, occ output and head data. Pointers wrap modulo 3.

Test Plan:
- Reset: hold rstn low with cmd_valid=1 → all outputs 0. The first cycle after release cmd_ready=0, the next cycle cmd_ready=1. No handshake occurs during reset.
- Single beat: FIFO holds {64'hDEADBEEF_CAFEF00D, 8'hFF}, cmd_len=0, wready=1.
  - Required: wvalid 3 cycles after handshake with wdata=64'hDEADBEEF_CAFEF00D, wstrb=8'hFF, wlast=1.
  - burst_done pulses once; exactly 1 fifo_rd_en.
- Full rate: FIFO prefilled with 16 incrementing words, cmd_len=15, wready=1.
  - Required: 16 consecutive beats with no bubbles, wlast only on beat 16, exactly 16 fifo_rd_en.
- Backpressure: cmd_len=7, wready random 50%.
  - Required: in-order data and stable W signals while stalled.
  - occ+inflight never exceeds 3; fifo_rd_en total = 8.
- Starvation: FIFO initially empty, one word pushed every 5 cycles, cmd_len=3.
  - Required: fifo_rd_en never while fifo_rd_empty, 4 beats in order, wlast on the 4th.
- Mid-burst reset: assert rstn low after 3 of 8 beats.
  - Required: outputs 0 during reset.
  - After release, a new cmd_len=1 burst gives 2 beats with the correct wlast.

Source files
------------

// File: rtl/master_wr_pkg.sv
// Shared widths, field offsets and FSM encoding for the
// master write-data FIFO drain.
package master_wr_pkg;

   localparam int DATA_W    = 64;
   localparam int STRB_W    = 8;
   localparam int FIFO_W    = DATA_W + STRB_W;
   localparam int LEN_W     = 8;
   localparam int STRB_LSB  = 0;
   localparam int DATA_LSB  = STRB_W;
   localparam int BUF_DEPTH = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_e;

   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == 2'(BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
   endfunction

endpackage

// File: rtl/wdata_out_buf.sv
// Three-entry skid buffer between the FIFO read port and
// the W channel; pointers wrap modulo three.
module wdata_out_buf
   import master_wr_pkg::*;
#(
   parameter int WIDTH = FIFO_W
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [1:0]       occ_o,
   output logic [WIDTH-1:0] head_o
);

   logic [WIDTH-1:0] mem_q [BUF_DEPTH];
   logic [1:0]       wr_ptr_q, wr_ptr_d;
   logic [1:0]       rd_ptr_q, rd_ptr_d;
   logic [1:0]       occ_q, occ_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
      unique case ({push_i, pop_i})
         2'b10:   occ_d = occ_q + 2'd1;
         2'b01:   occ_d = occ_q - 2'd1;
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   // Contents need no reset: they are only visible while occ != 0.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign occ_o  = occ_q;
   assign head_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/master_wr_data_fifo_drain.sv
// Pops len+1 words from the write-data FIFO and drives them
// on the AXI4 W channel with WLAST on the final beat.
module master_wr_data_fifo_drain
   import master_wr_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_W,
   parameter int STRB_WIDTH = STRB_W,
   parameter int FIFO_WIDTH = FIFO_W,
   parameter int LEN_WIDTH  = LEN_W
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [LEN_WIDTH-1:0]  cmd_len,
   output logic                  fifo_rd_en,
   input  logic [FIFO_WIDTH-1:0] fifo_rd_data,
   input  logic                  fifo_rd_empty,
   output logic                  m_axi_wvalid,
   input  logic                  m_axi_wready,
   output logic [DATA_WIDTH-1:0] m_axi_wdata,
   output logic [STRB_WIDTH-1:0] m_axi_wstrb,
   output logic                  m_axi_wlast,
   output logic                  busy,
   output logic                  burst_done
);

   localparam logic [LEN_WIDTH:0] REM_ONE = 1;

   state_e               state_q, state_d;
   logic [LEN_WIDTH:0]   fetch_rem_q, fetch_rem_d;
   logic [LEN_WIDTH:0]   send_rem_q, send_rem_d;
   logic                 inflight_q;
   logic                 cmd_ready_q, cmd_ready_d;
   logic                 burst_done_q, burst_done_d;
   logic [1:0]           occ;
   logic [FIFO_WIDTH-1:0] head;
   logic                 wvalid;
   logic                 pop;
   logic                 issue;

   assign wvalid = (occ != 2'd0);
   assign pop    = wvalid && m_axi_wready;

   // occ + inflight counts every word already owed a buffer slot.
   assign issue = (state_q == BURST) && (fetch_rem_q != '0) &&
                  !fifo_rd_empty &&
                  (({1'b0, occ} + {2'b0, inflight_q}) <= 3'd2);

   always_comb begin
      state_d      = state_q;
      fetch_rem_d  = fetch_rem_q;
      send_rem_d   = send_rem_q;
      burst_done_d = 1'b0;
      if (issue) fetch_rem_d = fetch_rem_q - REM_ONE;
      if (pop)   send_rem_d  = send_rem_q - REM_ONE;
      unique case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               fetch_rem_d = {1'b0, cmd_len} + REM_ONE;
               send_rem_d  = {1'b0, cmd_len} + REM_ONE;
               state_d     = BURST;
            end
         end
         BURST: begin
            if (pop && (send_rem_q == REM_ONE)) begin
               state_d      = IDLE;
               burst_done_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      cmd_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= IDLE;
         fetch_rem_q  <= '0;
         send_rem_q   <= '0;
         inflight_q   <= 1'b0;
         cmd_ready_q  <= 1'b0;
         burst_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         fetch_rem_q  <= fetch_rem_d;
         send_rem_q   <= send_rem_d;
         inflight_q   <= issue;
         cmd_ready_q  <= cmd_ready_d;
         burst_done_q <= burst_done_d;
      end
   end

   wdata_out_buf #(
      .WIDTH(FIFO_WIDTH)
   ) u_buf (
      .clk        (clk),
      .rstn       (rstn),
      .push_i     (inflight_q),
      .push_data_i(fifo_rd_data),
      .pop_i      (pop),
      .occ_o      (occ),
      .head_o     (head)
   );

   assign fifo_rd_en   = issue;
   assign cmd_ready    = cmd_ready_q;
   assign busy         = (state_q == BURST);
   assign burst_done   = burst_done_q;
   assign m_axi_wvalid = wvalid;
   assign m_axi_wlast  = wvalid && (send_rem_q == REM_ONE);
   assign m_axi_wdata  = wvalid ? head[FIFO_WIDTH-1:STRB_WIDTH] : '0;
   assign m_axi_wstrb  = wvalid ? head[STRB_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_master_wr_data_fifo_drain.sv
// Bench for master_wr_data_fifo_drain: FIFO model, W-channel
// scoreboard and a table of burst scenarios plus random bursts.
module tb_master_wr_data_fifo_drain;

   logic        clk = 1'b0;
   logic        rstn;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_len;
   logic        fifo_rd_en;
   logic [71:0] fifo_rd_data;
   logic        fifo_rd_empty;
   logic        wvalid;
   logic        wready;
   logic [63:0] wdata;
   logic [7:0]  wstrb;
   logic        wlast;
   logic        busy;
   logic        burst_done;

   always #5 clk = ~clk;

   master_wr_data_fifo_drain dut (
      .clk          (clk),
      .rstn         (rstn),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_len      (cmd_len),
      .fifo_rd_en   (fifo_rd_en),
      .fifo_rd_data (fifo_rd_data),
      .fifo_rd_empty(fifo_rd_empty),
      .m_axi_wvalid (wvalid),
      .m_axi_wready (wready),
      .m_axi_wdata  (wdata),
      .m_axi_wstrb  (wstrb),
      .m_axi_wlast  (wlast),
      .busy         (busy),
      .burst_done   (burst_done)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // FIFO model: words stored in push order, read data one cycle late.
   logic [71:0] fmem [0:4095];
   int wr_cnt = 0;
   int rd_cnt = 0;

   assign fifo_rd_empty = (wr_cnt == rd_cnt);

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_cnt       <= wr_cnt;
         fifo_rd_data <= '0;
      end else if (fifo_rd_en && (wr_cnt != rd_cnt)) begin
         fifo_rd_data <= fmem[rd_cnt];
         rd_cnt       <= rd_cnt + 1;
      end
   end

   task automatic check(input string name, input logic [71:0] act,
                        input logic [71:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard state, updated once per cycle at the falling edge.
   int cyc = 0;
   int sb_cnt = 0;
   int beat = 0;
   int cur_len = 0;
   int issued = 0;
   int popped = 0;
   int done_cnt = 0;
   int hs_cyc = 0;
   int first_cyc = -1;
   int last_cyc = 0;
   bit prev_last = 0;
   bit prev_stall = 0;
   logic [63:0] p_data;
   logic [7:0]  p_strb;
   logic        p_last;

   task automatic mon_step();
      cyc++;
      if (!rstn) begin
         sb_cnt = wr_cnt;
         beat = 0;
         issued = 0;
         popped = 0;
         prev_last = 0;
         prev_stall = 0;
         return;
      end
      check("outstanding_le3", 72'(issued - popped <= 3), 72'd1);
      if (fifo_rd_en) begin
         check("rd_en_when_empty", 72'(fifo_rd_empty), 72'd0);
         check("rd_en_room", 72'(issued - popped <= 2), 72'd1);
         issued++;
      end
      if (prev_stall) begin
         check("stall_wvalid", 72'(wvalid), 72'd1);
         check("stall_wdata", 72'(wdata), 72'(p_data));
         check("stall_wstrb", 72'(wstrb), 72'(p_strb));
         check("stall_wlast", 72'(wlast), 72'(p_last));
      end
      if (prev_last || burst_done) begin
         check("burst_done_pulse", 72'(burst_done), 72'(prev_last));
         if (burst_done) done_cnt++;
      end
      if (cmd_valid && cmd_ready) begin
         beat = 0;
         cur_len = int'(cmd_len);
         hs_cyc = cyc;
         first_cyc = -1;
      end
      if (wvalid && first_cyc < 0) first_cyc = cyc;
      prev_last = 0;
      if (wvalid && wready) begin
         check("wdata", 72'(wdata), 72'(fmem[sb_cnt][71:8]));
         check("wstrb", 72'(wstrb), 72'(fmem[sb_cnt][7:0]));
         check("wlast", 72'(wlast), 72'(beat == cur_len));
         if (beat == cur_len) begin
            prev_last = 1;
            last_cyc = cyc;
         end
         sb_cnt++;
         beat++;
         popped++;
      end
      prev_stall = wvalid && !wready;
      p_data = wdata;
      p_strb = wstrb;
      p_last = wlast;
   endtask

   typedef struct {
      int          len;
      int          pct;
      int          pre;
      int          gap;
      int          abort;
      logic [71:0] w0;
      int          exp_rd;
      int          exp_lat;
      int          exp_span;
   } vec_t;

   vec_t vecs [8];

   function automatic logic [71:0] rnd_word();
      return {$urandom(), $urandom(), 8'($urandom())};
   endfunction

   task automatic push_word(input logic [71:0] w);
      fmem[wr_cnt] = w;
      wr_cnt++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_burst(input vec_t v);
      int n;
      int pushed;
      int t;
      int rd0;
      int pop0;
      int done0;
      bit hs;
      n = v.len + 1;
      pushed = 0;
      for (int i = 0; i < v.pre && pushed < n; i++) begin
         push_word((i == 0 && v.w0 != '0) ? v.w0 : rnd_word());
         pushed++;
      end
      wready = ($urandom_range(1, 100) <= v.pct);
      cmd_len = 8'(v.len);
      cmd_valid = 1'b1;
      hs = 0;
      for (int k = 0; k < 50 && !hs; k++) begin
         @(negedge clk);
         hs = cmd_ready;
         rd0 = issued;
         pop0 = popped;
         done0 = done_cnt;
         step();
      end
      cmd_valid = 1'b0;
      if (!hs) begin
         check("cmd_handshake_timeout", 72'd1, 72'd0);
         return;
      end
      for (t = 0; t < 3000; t++) begin
         wready = ($urandom_range(1, 100) <= v.pct);
         if (pushed < n && (v.gap == 0 || t % v.gap == 0)) begin
            push_word(rnd_word());
            pushed++;
         end
         if (v.abort > 0 && beat >= v.abort) begin
            rstn = 1'b0;
            @(negedge clk);
            check("rst_ctrl", 72'({cmd_ready, fifo_rd_en, wvalid,
                               wlast, busy, burst_done}), 72'd0);
            check("rst_data", 72'({wdata, wstrb}), 72'd0);
            step();
            rstn = 1'b1;
            step();
            return;
         end
         if (done_cnt != done0) break;
         step();
      end
      if (t >= 3000) check("burst_timeout", 72'd1, 72'd0);
      check("rd_en_total", 72'(issued - rd0), 72'(v.exp_rd));
      check("beat_total", 72'(popped - pop0), 72'(n));
      check("burst_done_count", 72'(done_cnt - done0), 72'd1);
      if (v.exp_lat >= 0)
         check("first_wvalid_lat", 72'(first_cyc - hs_cyc),
               72'(v.exp_lat));
      if (v.exp_span >= 0)
         check("last_beat_span", 72'(last_cyc - hs_cyc),
               72'(v.exp_span));
   endtask

   initial begin
      fork
         forever begin
            @(negedge clk);
            mon_step();
         end
      join_none

      vecs[0] = '{0, 100, 1, 0, 0, 72'hDEADBEEF_CAFEF00D_FF, 1, 3, 3};
      vecs[1] = '{15, 100, 16, 0, 0, 72'h0, 16, 3, 18};
      vecs[2] = '{7, 50, 8, 0, 0, 72'h0, 8, 3, -1};
      vecs[3] = '{3, 100, 0, 5, 0, 72'h0, 4, -1, -1};
      vecs[4] = '{7, 100, 8, 0, 3, 72'h0, 0, -1, -1};
      vecs[5] = '{1, 100, 2, 0, 0, 72'h0, 2, 3, 4};
      vecs[6] = '{255, 80, 256, 0, 0, 72'h0, 256, 3, -1};
      vecs[7] = '{4, 30, 2, 2, 0, 72'h0, 5, 3, -1};

      rstn = 1'b0;
      cmd_valid = 1'b1;
      cmd_len = 8'd5;
      wready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("reset_ctrl", 72'({cmd_ready, fifo_rd_en, wvalid,
                              wlast, busy, burst_done}), 72'd0);
         check("reset_data", 72'({wdata, wstrb}), 72'd0);
      end
      step();
      rstn = 1'b1;
      @(negedge clk);
      check("cmd_ready_after_rel0", 72'(cmd_ready), 72'd0);
      step();
      cmd_valid = 1'b0;
      @(negedge clk);
      check("cmd_ready_after_rel1", 72'(cmd_ready), 72'd1);
      check("no_hs_in_reset", 72'(busy), 72'd0);
      step();

      for (int i = 0; i < 8; i++) run_burst(vecs[i]);

      for (int r = 0; r < 6; r++) begin
         vec_t v;
         v.len = $urandom_range(0, 20);
         v.pct = $urandom_range(40, 100);
         v.pre = $urandom_range(1, v.len + 1);
         v.gap = $urandom_range(0, 3);
         v.abort = 0;
         v.w0 = '0;
         v.exp_rd = v.len + 1;
         v.exp_lat = 3;
         v.exp_span = -1;
         run_burst(v);
      end

      repeat (3) step();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
